// File: rtl/alu_exec_unit.sv
// Single-cycle integer execute unit: decodes one dispatched op, registers the result and its ROB tag for the CDB,
// and supplies the JALR fetch target. Optional build macro ALU_TRACE_EN adds a cycle counter and a per-result trace print.
module alu_exec_unit #(
    parameter int unsigned VAL_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned OP_WIDTH     = 7,
    parameter int unsigned ROB_ID_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    flush,
    input  logic                    execute,
    input  logic [OP_WIDTH-1:0]     type_i,
    input  logic [VAL_WIDTH-1:0]    val1,
    input  logic [VAL_WIDTH-1:0]    val2,
    input  logic [ROB_ID_WIDTH:0]   entry,
    input  logic [ADDR_WIDTH-1:0]   nowPC,
    output logic                    aluReady,
    output logic [ROB_ID_WIDTH:0]   entry_out,
    output logic [VAL_WIDTH-1:0]    val_out,
    output logic [ADDR_WIDTH-1:0]   alu2if_pc,
    output logic                    alu2if_con
);

    localparam int unsigned CLASS_WIDTH = OP_WIDTH - 4;
    localparam int unsigned SHAMT_WIDTH = $clog2(VAL_WIDTH);

    localparam logic [CLASS_WIDTH-1:0] CLASS_R    = CLASS_WIDTH'(0);
    localparam logic [CLASS_WIDTH-1:0] CLASS_I    = CLASS_WIDTH'(1);
    localparam logic [CLASS_WIDTH-1:0] CLASS_BR   = CLASS_WIDTH'(2);
    localparam logic [CLASS_WIDTH-1:0] CLASS_MISC = CLASS_WIDTH'(3);

    logic [CLASS_WIDTH-1:0] op_class;
    logic [3:0]             op_sub;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic [VAL_WIDTH-1:0]   sum;
    logic [VAL_WIDTH-1:0]   diff;
    logic [VAL_WIDTH-1:0]   jalr_target;
    logic                   lt_s;
    logic                   lt_u;
    logic                   eq;

    logic [VAL_WIDTH-1:0]   result_c;
    logic                   is_jalr_c;

    logic                   ready_q,  ready_d;
    logic                   con_q,    con_d;
    logic [ROB_ID_WIDTH:0]  entry_q,  entry_d;
    logic [VAL_WIDTH-1:0]   val_q,    val_d;
    logic [ADDR_WIDTH-1:0]  pc_q,     pc_d;

    // The decoder PC is carried on the interface only; the datapath never needs it.
    logic unused_now_pc;
    assign unused_now_pc = ^nowPC;

    assign op_class    = type_i[OP_WIDTH-1:4];
    assign op_sub      = type_i[3:0];
    assign shamt       = val2[SHAMT_WIDTH-1:0];
    assign sum         = val1 + val2;
    assign diff        = val1 - val2;
    assign jalr_target = {sum[VAL_WIDTH-1:1], 1'b0};
    assign lt_s        = $signed(val1) < $signed(val2);
    assign lt_u        = val1 < val2;
    assign eq          = val1 == val2;

    // Result decode; anything not listed yields zero but still completes.
    always_comb begin
        result_c  = '0;
        is_jalr_c = 1'b0;
        case (op_class)
            CLASS_R, CLASS_I: begin
                case (op_sub)
                    4'h0: result_c = sum;
                    4'h1: if (op_class == CLASS_R) result_c = diff;
                    4'h2: result_c = val1 << shamt;
                    4'h3: result_c = VAL_WIDTH'(lt_s);
                    4'h4: result_c = VAL_WIDTH'(lt_u);
                    4'h5: result_c = val1 ^ val2;
                    4'h6: result_c = val1 >> shamt;
                    4'h7: result_c = VAL_WIDTH'($signed(val1) >>> shamt);
                    4'h8: result_c = val1 | val2;
                    4'h9: result_c = val1 & val2;
                    4'hA: begin
                        if (op_class == CLASS_I) begin
                            result_c  = jalr_target;
                            is_jalr_c = 1'b1;
                        end
                    end
                    default: result_c = '0;
                endcase
            end
            CLASS_BR: begin
                case (op_sub)
                    4'h0: result_c = VAL_WIDTH'(eq);
                    4'h1: result_c = VAL_WIDTH'(!eq);
                    4'h2: result_c = VAL_WIDTH'(lt_s);
                    4'h3: result_c = VAL_WIDTH'(!lt_s);
                    4'h4: result_c = VAL_WIDTH'(lt_u);
                    4'h5: result_c = VAL_WIDTH'(!lt_u);
                    default: result_c = '0;
                endcase
            end
            CLASS_MISC: begin
                case (op_sub)
                    4'h0:       result_c = val1;
                    4'h1, 4'h2: result_c = sum;
                    default:    result_c = '0;
                endcase
            end
            default: result_c = '0;
        endcase
    end

    // Next-state: flush clears like reset; data registers hold when nothing dispatches.
    always_comb begin
        ready_d = ready_q;
        con_d   = con_q;
        entry_d = entry_q;
        val_d   = val_q;
        pc_d    = pc_q;
        if (rdy_in) begin
            if (flush) begin
                ready_d = 1'b0;
                con_d   = 1'b0;
                entry_d = '0;
                val_d   = '0;
                pc_d    = '0;
            end else begin
                ready_d = execute;
                con_d   = execute && is_jalr_c;
                if (execute) begin
                    entry_d = entry;
                    val_d   = result_c;
                    if (is_jalr_c) pc_d = ADDR_WIDTH'(jalr_target);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_in) begin
            ready_q <= 1'b0;
            con_q   <= 1'b0;
            entry_q <= '0;
            val_q   <= '0;
            pc_q    <= '0;
        end else begin
            ready_q <= ready_d;
            con_q   <= con_d;
            entry_q <= entry_d;
            val_q   <= val_d;
            pc_q    <= pc_d;
        end
    end

    assign aluReady   = ready_q;
    assign alu2if_con = con_q;
    assign entry_out  = entry_q;
    assign val_out    = val_q;
    assign alu2if_pc  = pc_q;

`ifdef ALU_TRACE_EN
    logic [31:0] cycle_q;

    always_ff @(posedge clk) begin
        if (!rst_in) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    // One trace line per edge that produces a result.
    always_ff @(posedge clk) begin
        if (rst_in && rdy_in && !flush && execute) begin
            $display("alu trace: cycle=%0d type=%h entry=%0d val1=%h val2=%h val_out=%h",
                     cycle_q, type_i, entry, val1, val2, result_c);
        end
    end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed cases for the documented corner values, then randomized traffic
// checked against an opcode-table reference model.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in, flush, execute;
    logic [6:0]  type_i;
    logic [31:0] val1, val2, nowPC;
    logic [4:0]  entry;
    logic        aluReady, alu2if_con;
    logic [4:0]  entry_out;
    logic [31:0] val_out, alu2if_pc;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state
    logic        m_ready, m_con;
    logic [4:0]  m_entry;
    logic [31:0] m_val, m_pc;

    always #5 clk = ~clk;

    alu_exec_unit dut (
        .clk       (clk),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .flush     (flush),
        .execute   (execute),
        .type_i    (type_i),
        .val1      (val1),
        .val2      (val2),
        .entry     (entry),
        .nowPC     (nowPC),
        .aluReady  (aluReady),
        .entry_out (entry_out),
        .val_out   (val_out),
        .alu2if_pc (alu2if_pc),
        .alu2if_con(alu2if_con)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Returns {is_jalr, result} straight from the opcode table.
    function automatic logic [32:0] ref_op(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        j;
        int          sh;
        r  = 32'd0;
        j  = 1'b0;
        sh = int'(b % 32);
        case (op)
            7'h00, 7'h10: r = a + b;
            7'h01:        r = a - b;
            7'h02, 7'h12: r = a << sh;
            7'h03, 7'h13: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            7'h04, 7'h14: r = (a < b) ? 32'd1 : 32'd0;
            7'h05, 7'h15: r = a ^ b;
            7'h06, 7'h16: r = a >> sh;
            7'h07, 7'h17: r = $signed(a) >>> sh;
            7'h08, 7'h18: r = a | b;
            7'h09, 7'h19: r = a & b;
            7'h1A: begin r = (a + b) & 32'hFFFF_FFFE; j = 1'b1; end
            7'h20: r = (a == b) ? 32'd1 : 32'd0;
            7'h21: r = (a != b) ? 32'd1 : 32'd0;
            7'h22: r = ($signed(a) <  $signed(b)) ? 32'd1 : 32'd0;
            7'h23: r = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
            7'h24: r = (a <  b) ? 32'd1 : 32'd0;
            7'h25: r = (a >= b) ? 32'd1 : 32'd0;
            7'h30: r = a;
            7'h31, 7'h32: r = a + b;
            default: r = 32'd0;
        endcase
        return {j, r};
    endfunction

    // Advance one edge, update the reference from the applied inputs, compare all outputs.
    task automatic tick(input string t);
        logic [32:0] r;
        r = ref_op(type_i, val1, val2);
        if (!rst_in || (rdy_in && flush)) begin
            m_ready = 1'b0; m_con = 1'b0; m_entry = '0; m_val = '0; m_pc = '0;
        end else if (rdy_in) begin
            m_ready = execute;
            m_con   = execute && r[32];
            if (execute) begin
                m_entry = entry;
                m_val   = r[31:0];
                if (r[32]) m_pc = r[31:0];
            end
        end
        @(posedge clk);
        #1;
        check_eq({t, ".rdy"},   32'(aluReady),   32'(m_ready));
        check_eq({t, ".con"},   32'(alu2if_con), 32'(m_con));
        check_eq({t, ".entry"}, 32'(entry_out),  32'(m_entry));
        check_eq({t, ".val"},   val_out,         m_val);
        check_eq({t, ".pc"},    alu2if_pc,       m_pc);
    endtask

    task automatic issue(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        execute = 1'b1; type_i = op; val1 = a; val2 = b; entry = tag;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; flush = 1'b0; execute = 1'b0;
        type_i = '0; val1 = '0; val2 = '0; entry = '0; nowPC = 32'h100;
        m_ready = 1'b0; m_con = 1'b0; m_entry = '0; m_val = '0; m_pc = '0;

        // Reset held for two edges, then idle
        tick("rst0");
        tick("rst1");
        check_eq("rst.val_lit", val_out, 32'd0);
        rst_in = 1'b1;
        tick("idle");
        check_eq("idle.rdy_lit", 32'(aluReady), 32'd0);

        issue(7'h01, 32'd5, 32'd7, 5'd3);
        tick("sub");
        check_eq("sub.val_lit", val_out, 32'hFFFF_FFFE);
        check_eq("sub.entry_lit", 32'(entry_out), 32'd3);
        execute = 1'b0;
        tick("sub_after");
        check_eq("sub_after.rdy_lit", 32'(aluReady), 32'd0);

        issue(7'h07, 32'h8000_0000, 32'd4, 5'd1);
        tick("sra");
        check_eq("sra.val_lit", val_out, 32'hF800_0000);
        issue(7'h16, 32'h8000_0000, 32'd4, 5'd2);
        tick("srli");
        check_eq("srli.val_lit", val_out, 32'h0800_0000);

        issue(7'h04, 32'hFFFF_FFFF, 32'd1, 5'd4);
        tick("sltu");
        check_eq("sltu.val_lit", val_out, 32'd0);
        issue(7'h03, 32'hFFFF_FFFF, 32'd1, 5'd5);
        tick("slt");
        check_eq("slt.val_lit", val_out, 32'd1);
        issue(7'h23, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
        tick("bge");
        check_eq("bge.val_lit", val_out, 32'd1);

        issue(7'h1A, 32'h1001, 32'h10, 5'd6);
        tick("jalr");
        check_eq("jalr.con_lit", 32'(alu2if_con), 32'd1);
        check_eq("jalr.pc_lit", alu2if_pc, 32'h1010);
        check_eq("jalr.val_lit", val_out, 32'h1010);
        check_eq("jalr.entry_lit", 32'(entry_out), 32'd6);
        execute = 1'b0;
        tick("jalr_after");
        check_eq("jalr_after.con_lit", 32'(alu2if_con), 32'd0);

        // Stall: outputs frozen at the last JALR result
        rdy_in = 1'b0;
        issue(7'h00, 32'd1, 32'd2, 5'd9);
        tick("stall");
        check_eq("stall.val_lit", val_out, 32'h1010);
        rdy_in = 1'b1;
        flush  = 1'b1;
        tick("flush");
        check_eq("flush.rdy_lit", 32'(aluReady), 32'd0);
        flush = 1'b0;

        for (int i = 0; i < 3; i++) begin
            issue(7'h00, 32'(i), 32'd100, 5'(i + 10));
            tick("b2b");
            check_eq("b2b.rdy_lit", 32'(aluReady), 32'd1);
            check_eq("b2b.entry_lit", 32'(entry_out), 32'(i + 10));
            check_eq("b2b.val_lit", val_out, 32'(i + 100));
        end

        // Randomized traffic including stalls, flushes and resets
        for (int i = 0; i < 600; i++) begin
            rst_in  = ($urandom_range(0, 49) != 0);
            rdy_in  = ($urandom_range(0, 9) != 0);
            flush   = ($urandom_range(0, 19) == 0);
            execute = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 4))
                0:       type_i = 7'($urandom_range(0, 9));
                1:       type_i = 7'h10 | 7'($urandom_range(0, 10));
                2:       type_i = 7'h20 | 7'($urandom_range(0, 5));
                3:       type_i = 7'h30 | 7'($urandom_range(0, 2));
                default: type_i = 7'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) type_i = 7'h1A;
            val1  = pick_val();
            val2  = pick_val();
            entry = 5'($urandom);
            nowPC = $urandom;
            tick("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
